pc_redirect_sequencer: RTL

- Program-counter sequencer feeding the fetch stage of the soft RISC CPU in the digit-recognition core.
- Consumes the latched branch destination address and a taken strobe from the execute-stage register, and produces the next PC.
- Tracks stalls, holds a redirect that arrives while the pipeline is stalled, and emits a one-cycle Flush to squash wrong-path instructions.

---
 rtl/pc_seq_pkg.sv | 22 ++
 rtl/redirect_hold_reg.sv | 24 ++
 rtl/pc_redirect_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared state encoding, reset/step defaults and alignment helper for pc_redirect_sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2,
        HALTED  = 2'd3
    } pc_seq_state_e;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_INSTR_BYTES   = 4;
    localparam int unsigned PC_ALIGN_W       = $clog2(PC_INSTR_BYTES);

    // True when any of the low log2(instr_bytes) address bits is set.
    function automatic logic is_misaligned(input logic [63:0] addr, input int unsigned instr_bytes);
        logic [63:0] mask;
        mask = 64'(instr_bytes) - 64'd1;
        return (addr & mask) != '0;
    endfunction

endpackage

// File: rtl/redirect_hold_reg.sv
// Holds the pending redirect target while the pipeline is stalled.
module redirect_hold_reg #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] d_i,
    output logic [ADDR_W-1:0] q_o
);

    logic [ADDR_W-1:0] hold_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q <= '0;
        end else if (load_i) begin
            hold_q <= d_i;
        end
    end

    assign q_o = hold_q;

endmodule

// File: rtl/pc_redirect_sequencer.sv
// Fetch PC sequencer with stall-deferred redirects and a one-cycle Flush pulse.
// Optional macro PC_MISALIGN_TRAP_EN adds MisalignErr and traps unaligned redirect targets.
module pc_redirect_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(PC_RESET_DEFAULT),
    parameter int unsigned       INSTR_BYTES = PC_INSTR_BYTES
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Tick,
    input  logic              Stall,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchDest,
    input  logic              Halt,
    output logic [ADDR_W-1:0] PC,
    output logic              PcValid,
    output logic              Flush,
    output logic              Halted
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic              MisalignErr
`endif
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

    pc_seq_state_e     state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q;
    logic [ADDR_W-1:0] redir_tgt;
    logic              redir_req;
    logic              hold_load;
    logic              flush_q, flush_d;
`ifdef PC_MISALIGN_TRAP_EN
    logic              mis_q, mis_d;
`endif

    redirect_hold_reg #(
        .ADDR_W (ADDR_W)
    ) u_hold (
        .clk_i  (Clock),
        .rst_ni (Reset),
        .load_i (hold_load),
        .d_i    (BranchDest),
        .q_o    (pend_q)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        flush_d   = flush_q;
        hold_load = 1'b0;
        redir_req = 1'b0;
        redir_tgt = BranchDest;
`ifdef PC_MISALIGN_TRAP_EN
        mis_d     = mis_q;
`endif
        if (Tick) begin
            flush_d = 1'b0;
            case (state_q)
                BOOT: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (Halt) begin
                        state_d = HALTED;
                    end else if (BranchTaken && !Stall) begin
                        redir_req = 1'b1;
                    end else if (BranchTaken) begin
                        hold_load = 1'b1;
                        state_d   = PENDING;
                    end else if (!Stall) begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
                PENDING: begin
                    // A newer request overwrites the held target; unstalled, it is taken directly.
                    if (Halt) begin
                        state_d = HALTED;
                    end else if (BranchTaken) begin
                        hold_load = 1'b1;
                        if (!Stall) begin
                            redir_req = 1'b1;
                            state_d   = RUN;
                        end
                    end else if (!Stall) begin
                        redir_req = 1'b1;
                        redir_tgt = pend_q;
                        state_d   = RUN;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = state_q;
                end
            endcase

            if (redir_req) begin
`ifdef PC_MISALIGN_TRAP_EN
                if (is_misaligned(64'(redir_tgt), INSTR_BYTES)) begin
                    state_d = HALTED;
                    mis_d   = 1'b1;
                end else begin
                    pc_d    = redir_tgt;
                    flush_d = 1'b1;
                end
`else
                pc_d    = redir_tgt;
                flush_d = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign MisalignErr = mis_q;
`endif

    assign PC      = pc_q;
    assign Flush   = flush_q;
    assign PcValid = (state_q == RUN) || (state_q == PENDING);
    assign Halted  = (state_q == HALTED);

endmodule
